// File: rtl/clock_pkg.sv
// Shared definitions for the clock chain (seconds, minutes, hours stages).
// Holds the BCD digit limits, the default system clock rate and the small
// helpers every stage uses to validate and represent BCD time values.
package clock_pkg;

    // Largest legal tens digit for seconds and minutes (59 max).
    localparam int SEC_TENS_MAX   = 5;
    // Largest legal ones digit for any BCD digit.
    localparam int BCD_ONES_MAX   = 9;
    // System clock rate of the production board.
    localparam int DEFAULT_CLK_HZ = 50_000_000;

    typedef logic [3:0] bcd_digit_t;

    // A seconds (or minutes) value held as two BCD digits.
    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_sec_t;

    // What the digit register does in a given cycle, in priority order
    // clear > load > tick > hold.
    typedef enum logic [1:0] {
        SEC_HOLD  = 2'd0,
        SEC_CLEAR = 2'd1,
        SEC_LOAD  = 2'd2,
        SEC_TICK  = 2'd3
    } sec_op_t;

    // True when tens/ones form a legal 00..59 value.
    function automatic logic bcd_sec_valid(input bcd_digit_t tens,
                                           input bcd_digit_t ones);
        return (tens <= 4'(SEC_TENS_MAX)) && (ones <= 4'(BCD_ONES_MAX));
    endfunction

endpackage : clock_pkg

// File: rtl/tick_prescaler.sv
// Free-running divide-by-CLK_HZ prescaler.
// Counts 0..CLK_HZ-1 while en is high and holds while en is low. The tick
// output is a combinational strobe that is high during the single cycle in
// which the counter sits on its terminal value and is about to wrap, so a
// consumer can act on the very edge where the wrap happens (and register the
// strobe if it wants a clean pulse). sync_clr restarts the period and
// suppresses a tick that would otherwise fire in that cycle.
module tick_prescaler
    import clock_pkg::*;
#(
    parameter int CLK_HZ = DEFAULT_CLK_HZ,
    parameter int CNT_W  = $clog2(CLK_HZ)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);
    assign tick    = en && !sync_clr && at_last;

    // Period counter: clear wins, otherwise advance and wrap while enabled.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours; blocking here would create
    // order-dependent simulation that no longer matches the flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/second_counter.sv
// Seconds stage of the clock chain.
// Divides the system clock to a 1 Hz tick, counts 00..59 in BCD and emits a
// one-cycle sec_carry on the 59->00 wrap for the minute stage. clr and load
// serve the time-adjust buttons and act whether or not the clock is running.
// The digits change on the same edge that raises tick_1hz; the minute stage
// sees sec_carry one clk after the wrap, which is the intended skew.
module second_counter
    import clock_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int PRESCALE_W = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic       tick_1hz,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_carry,
    output logic       load_err
);

    bcd_sec_t sec_q;
    bcd_sec_t sec_d;
    sec_op_t  sec_op;
    logic     carry_d;
    logic     load_in_range;
    logic     load_ok;
    logic     load_bad;
    logic     presc_clr;
    logic     tick_now;

    // A load only counts when clr is not also asserted; an out-of-range value
    // is rejected without touching the digits or the prescaler.
    assign load_in_range = bcd_sec_valid(load_tens, load_ones);
    assign load_ok       = load && !clr && load_in_range;
    assign load_bad      = load && !clr && !load_in_range;

    // Both clear and an accepted load restart the second, which also swallows
    // a tick that was due in that cycle.
    assign presc_clr = clr || load_ok;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (run),
        .sync_clr (presc_clr),
        .tick     (tick_now)
    );

    // Pick this cycle's digit operation in priority order.
    // NOTE: every signal assigned in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sec_op = SEC_HOLD;
        if (clr) begin
            sec_op = SEC_CLEAR;
        end else if (load_ok) begin
            sec_op = SEC_LOAD;
        end else if (tick_now) begin
            sec_op = SEC_TICK;
        end
    end

    // Next digit value and wrap carry; BCD increment with explicit digit
    // rollover rather than any divide/modulo arithmetic.
    always_comb begin
        sec_d   = sec_q;
        carry_d = 1'b0;
        case (sec_op)
            SEC_CLEAR: begin
                sec_d = '0;
            end
            SEC_LOAD: begin
                sec_d.tens = load_tens;
                sec_d.ones = load_ones;
            end
            SEC_TICK: begin
                if (sec_q.ones == 4'(BCD_ONES_MAX)) begin
                    sec_d.ones = '0;
                    if (sec_q.tens == 4'(SEC_TENS_MAX)) begin
                        sec_d.tens = '0;
                        carry_d    = 1'b1;
                    end else begin
                        sec_d.tens = sec_q.tens + 4'd1;
                    end
                end else begin
                    sec_d.ones = sec_q.ones + 4'd1;
                end
            end
            default: begin
                sec_d = sec_q;
            end
        endcase
    end

    // Digit register plus the registered strobes, all cleared by reset so a
    // pending tick or carry is dropped the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_q     <= '0;
            tick_1hz  <= 1'b0;
            sec_carry <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            tick_1hz  <= tick_now;
            sec_carry <= carry_d;
            load_err  <= load_bad;
        end
    end

    assign sec_tens = sec_q.tens;
    assign sec_ones = sec_q.ones;

endmodule : second_counter

// File: tb/tb_second_counter.sv
// Self-checking bench for second_counter with CLK_HZ=4.
// A behavioural model tracks the prescaler phase and the seconds value as
// plain integers; a compare process checks every DUT output against it on
// each falling edge. Directed scenarios add hand-computed expectations, then
// a randomized phase exercises run/clr/load/reset mixes.
module tb_second_counter;

    localparam int HZ = 4;

    logic       clk;
    logic       reset_n;
    logic       run;
    logic       clr;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       tick_1hz;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_carry;
    logic       load_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;
    int carry_seen = 0;

    // Model state: phase within the current second and seconds as 0..59.
    int m_pre   = 0;
    int m_sec   = 0;
    bit m_tick  = 1'b0;
    bit m_carry = 1'b0;
    bit m_err   = 1'b0;

    second_counter #(
        .CLK_HZ     (HZ),
        .PRESCALE_W (3)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .run       (run),
        .clr       (clr),
        .load      (load),
        .load_tens (load_tens),
        .load_ones (load_ones),
        .tick_1hz  (tick_1hz),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .sec_carry (sec_carry),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre   = 0;
        m_sec   = 0;
        m_tick  = 1'b0;
        m_carry = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference behaviour, one clock edge at a time.
    always @(posedge clk) begin
        if (!reset_n) begin
            model_reset();
        end else begin
            m_tick  = 1'b0;
            m_carry = 1'b0;
            m_err   = 1'b0;
            if (clr) begin
                m_pre = 0;
                m_sec = 0;
            end else if (load && load_tens <= 5 && load_ones <= 9) begin
                m_sec = int'(load_tens) * 10 + int'(load_ones);
                m_pre = 0;
            end else begin
                m_err = load;
                if (run) begin
                    if (m_pre == HZ - 1) begin
                        m_pre   = 0;
                        m_tick  = 1'b1;
                        m_sec   = (m_sec + 1) % 60;
                        m_carry = (m_sec == 0);
                    end else begin
                        m_pre++;
                    end
                end
            end
        end
    end

    always @(negedge reset_n) model_reset();

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("tick_1hz",  int'(tick_1hz),  int'(m_tick));
            check("sec_tens",  int'(sec_tens),  m_sec / 10);
            check("sec_ones",  int'(sec_ones),  m_sec % 10);
            check("sec_carry", int'(sec_carry), int'(m_carry));
            check("load_err",  int'(load_err),  int'(m_err));
            if (sec_carry) carry_seen++;
        end
    end

    task automatic do_load(input int t, input int o);
        load      = 1'b1;
        load_tens = 4'(t);
        load_ones = 4'(o);
        step(1);
        load      = 1'b0;
    endtask

    initial begin
        run       = 1'b0;
        clr       = 1'b0;
        load      = 1'b0;
        load_tens = '0;
        load_ones = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        step(3);
        cmp_en = 1'b1;
        check("reset_tick",  int'(tick_1hz),  0);
        check("reset_tens",  int'(sec_tens),  0);
        check("reset_carry", int'(sec_carry), 0);

        // 1: count 00..10 from reset release, one tick per 4 cycles.
        reset_n = 1'b1;
        run     = 1'b1;
        step(3);
        check("t1_no_early_tick", int'(tick_1hz), 0);
        step(1);
        check("t1_first_tick", int'(tick_1hz), 1);
        check("t1_first_ones", int'(sec_ones), 1);
        step(36);
        check("t1_tens_10", int'(sec_tens), 1);
        check("t1_ones_10", int'(sec_ones), 0);
        check("t1_no_carry", carry_seen, 0);

        // 2: 58 -> 59 -> 00 with carry, then 01.
        do_load(5, 8);
        step(4);
        check("t2_59_ones", int'(sec_ones), 9);
        step(4);
        check("t2_wrap_tens", int'(sec_tens), 0);
        check("t2_wrap_ones", int'(sec_ones), 0);
        check("t2_carry", int'(sec_carry), 1);
        step(1);
        check("t2_carry_drop", int'(sec_carry), 0);
        step(3);
        check("t2_next_01", int'(sec_ones), 1);
        check("t2_next_tick", int'(tick_1hz), 1);

        // 3: rejected loads at 23 leave digits and phase alone.
        do_load(2, 3);
        step(1);
        do_load(6, 0);
        check("t3_err_tens6", int'(load_err), 1);
        check("t3_hold_tens", int'(sec_tens), 2);
        check("t3_hold_ones", int'(sec_ones), 3);
        step(1);
        check("t3_err_pulse", int'(load_err), 0);
        step(1);
        check("t3_phase_tick", int'(tick_1hz), 1);
        check("t3_phase_24", int'(sec_ones), 4);
        do_load(2, 10);
        check("t3_err_ones10", int'(load_err), 1);
        check("t3_hold_24", int'(sec_ones), 4);

        // 4: clr + load together at 59 with a tick due.
        do_load(5, 9);
        step(3);
        clr = 1'b1;
        load = 1'b1;
        load_tens = 4'd3;
        load_ones = 4'd0;
        step(1);
        clr = 1'b0;
        load = 1'b0;
        check("t4_tens", int'(sec_tens), 0);
        check("t4_ones", int'(sec_ones), 0);
        check("t4_no_carry", int'(sec_carry), 0);
        check("t4_no_err", int'(load_err), 0);
        check("t4_no_tick", int'(tick_1hz), 0);
        step(4);
        check("t4_restart_tick", int'(tick_1hz), 1);
        check("t4_restart_01", int'(sec_ones), 1);

        // 5: pause mid-period, resume with only the remainder.
        step(2);
        run = 1'b0;
        step(10);
        check("t5_frozen", int'(sec_ones), 1);
        run = 1'b1;
        step(1);
        check("t5_not_yet", int'(tick_1hz), 0);
        step(1);
        check("t5_resume_tick", int'(tick_1hz), 1);
        check("t5_resume_02", int'(sec_ones), 2);

        // 6: async reset at 59 with a tick pending.
        do_load(5, 9);
        step(3);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_tens", int'(sec_tens), 0);
        check("t6_async_ones", int'(sec_ones), 0);
        step(1);
        check("t6_no_carry", int'(sec_carry), 0);
        check("t6_no_tick", int'(tick_1hz), 0);
        reset_n = 1'b1;
        step(3);
        check("t6_wait", int'(tick_1hz), 0);
        step(1);
        check("t6_first_tick", int'(tick_1hz), 1);
        check("t6_first_01", int'(sec_ones), 1);

        // Randomized mix checked against the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            run       = ($urandom % 8) != 0;
            clr       = ($urandom % 50) == 0;
            load      = ($urandom % 12) == 0;
            load_tens = 4'($urandom % 8);
            load_ones = 4'($urandom % 12);
            // Keep rejected loads off cycles where a tick is due.
            if (load && !clr && !(load_tens <= 5 && load_ones <= 9)
                && run && m_pre == HZ - 1)
                load = 1'b0;
            if (($urandom % 400) == 0) begin
                #2 reset_n = 1'b0;
                #1;
                check("rand_async_tens", int'(sec_tens), 0);
                check("rand_async_ones", int'(sec_ones), 0);
                @(negedge clk);
                reset_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_second_counter
